// File: rtl/bno055_pkg.sv
// Shared constants and state encoding for the BNO055 Euler-angle sequencer.
package bno055_pkg;

    localparam logic [7:0] EUL_BASE = 8'h1A;
    localparam logic [7:0] CHIP_ID  = 8'h00;

    localparam int EUL_FRAME_BYTES = 6;
    localparam int EUL_LSB_PER_DEG = 16;

    localparam logic [2:0] LAST_IDX = 3'(EUL_FRAME_BYTES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_STORE   = 3'd3;
    localparam logic [2:0] ST_PUBLISH = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ISSUE   = ST_ISSUE,
        S_WAIT    = ST_WAIT,
        S_STORE   = ST_STORE,
        S_PUBLISH = ST_PUBLISH
    } state_t;

    // BNO055 multi-byte registers are little-endian
    function automatic logic [15:0] le16(input logic [7:0] lo,
                                         input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/bno055_euler_sequencer_if.sv
// Request/response bus between the sequencer and the single-byte read core.
interface bno055_euler_sequencer_if;

    logic [7:0] rd_addr;
    logic       rd_start;
    logic [7:0] rd_data;
    logic       rd_done;

    modport master (
        output rd_addr,
        output rd_start,
        input  rd_data,
        input  rd_done
    );

    modport slave (
        input  rd_addr,
        input  rd_start,
        output rd_data,
        output rd_done
    );

endinterface

// File: rtl/bno055_poll_timer.sv
// Free-running counter with enable/clear; o_tc marks the last count.
module bno055_poll_timer #(
    parameter int unsigned N = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int W = (N > 2) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = (N == 0) ? '0 : W'(N - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    // N == 0 means the timer never expires
    assign w_last = (N != 0) && (r_cnt == LAST);
    assign o_tc   = i_en && w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/bno055_euler_sequencer.sv
// Reads the six Euler registers through the read core and publishes heading/roll/pitch.
module bno055_euler_sequencer
    import bno055_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR      = EUL_BASE,
    parameter int unsigned POLL_CYCLES    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    bno055_euler_sequencer_if.master         rd_bus,
    output logic [15:0]                      o_heading,
    output logic [15:0]                      o_roll,
    output logic [15:0]                      o_pitch,
    output logic                             o_frame_valid,
    output logic                             o_busy,
    output logic                             o_timeout,
    output logic                             o_err_flag
);

    state_t r_state;
    state_t w_next;

    logic [2:0]                          r_idx;
    logic [EUL_FRAME_BYTES-1:0][7:0]     r_bytes;
    logic [7:0]                          r_addr;
    logic [15:0]                         r_heading;
    logic [15:0]                         r_roll;
    logic [15:0]                         r_pitch;
    logic                                r_frame_valid;
    logic                                r_busy;
    logic                                r_timeout;
    logic                                r_err;

    logic w_in_idle;
    logic w_in_wait;
    logic w_poll_tc;
    logic w_to_tc;
    logic w_trigger;
    logic w_capture;
    logic w_abort;
    logic w_advance;
    logic w_publish;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_in_wait = (r_state == S_WAIT);

    bno055_poll_timer #(.N(POLL_CYCLES)) u_poll (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_in_idle),
        .i_clr   (!w_in_idle),
        .o_tc    (w_poll_tc)
    );

    bno055_poll_timer #(.N(TIMEOUT_CYCLES)) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_in_wait),
        .i_clr   (!w_in_wait),
        .o_tc    (w_to_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_trigger = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        w_advance = 1'b0;
        w_publish = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start || w_poll_tc) begin
                    w_trigger = 1'b1;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // a completion arriving on the expiry cycle still counts
                if (rd_bus.rd_done) begin
                    w_capture = 1'b1;
                    w_next    = S_STORE;
                end else if (w_to_tc) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_STORE: begin
                if (r_idx == LAST_IDX) begin
                    w_next = S_PUBLISH;
                end else begin
                    w_advance = 1'b1;
                    w_next    = S_ISSUE;
                end
            end
            S_PUBLISH: begin
                w_publish = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx         <= '0;
            r_bytes       <= '0;
            r_addr        <= '0;
            r_heading     <= '0;
            r_roll        <= '0;
            r_pitch       <= '0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_frame_valid <= w_publish;
            r_timeout     <= w_abort;
            if (w_trigger) begin
                r_idx  <= '0;
                r_addr <= BASE_ADDR;
                r_busy <= 1'b1;
            end
            if (w_advance) begin
                r_idx  <= r_idx + 3'd1;
                r_addr <= BASE_ADDR + {5'd0, r_idx} + 8'd1;
            end
            if (w_capture) begin
                r_bytes[r_idx] <= rd_bus.rd_data;
            end
            if (w_abort) begin
                r_busy <= 1'b0;
                r_err  <= 1'b1;
            end
            // words only change here, so a partial frame is never visible
            if (w_publish) begin
                r_heading <= le16(r_bytes[0], r_bytes[1]);
                r_roll    <= le16(r_bytes[2], r_bytes[3]);
                r_pitch   <= le16(r_bytes[4], r_bytes[5]);
                r_busy    <= 1'b0;
                r_err     <= 1'b0;
            end
        end
    end

    assign rd_bus.rd_addr  = r_addr;
    assign rd_bus.rd_start = (r_state == S_ISSUE);

    assign o_heading     = r_heading;
    assign o_roll        = r_roll;
    assign o_pitch       = r_pitch;
    assign o_frame_valid = r_frame_valid;
    assign o_busy        = r_busy;
    assign o_timeout     = r_timeout;
    assign o_err_flag    = r_err;

endmodule

// File: tb/tb_bno055_euler_sequencer.sv
// Randomized bench: read-core responder plus an event-scheduled frame model.
module tb_bno055_euler_sequencer;

    localparam logic [7:0] BASE = 8'h1A;
    localparam int POLL = 50;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] heading, roll, pitch;
    logic        fv, busy, tmo, err;

    bno055_euler_sequencer_if rd_bus ();

    bno055_euler_sequencer #(
        .BASE_ADDR      (BASE),
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .rd_bus        (rd_bus),
        .o_heading     (heading),
        .o_roll        (roll),
        .o_pitch       (pitch),
        .o_frame_valid (fv),
        .o_busy        (busy),
        .o_timeout     (tmo),
        .o_err_flag    (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- read-core responder ----------------
    int  resp_lat = 5;
    bit  lat_rand = 0;
    bit  table_mode = 0;
    int  withhold_k = -1;
    bit  stray_store = 0;
    bit  stray_idle_req = 0;
    logic [7:0] tbl [6];

    initial begin
        int cnt;
        int idx;
        bit stray_next;
        tbl = '{8'h10, 8'h00, 8'hF0, 8'hFF, 8'h20, 8'h00};
        cnt = 0; idx = 0; stray_next = 0;
        rd_bus.rd_done = 1'b0;
        rd_bus.rd_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            rd_bus.rd_done = 1'b0;
            rd_bus.rd_data = 8'($urandom);
            if (!rst_n) begin
                cnt = 0; stray_next = 0;
            end else if (rd_bus.rd_start) begin
                cnt = lat_rand ? int'($urandom_range(1, 8)) : resp_lat;
                idx = int'(8'(rd_bus.rd_addr - BASE));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && idx != withhold_k) begin
                    rd_bus.rd_done = 1'b1;
                    if (table_mode && idx >= 0 && idx < 6) rd_bus.rd_data = tbl[idx];
                    stray_next = stray_store;
                end
            end else if (stray_next) begin
                stray_next = 0;
                rd_bus.rd_done = 1'b1;
            end else if (stray_idle_req) begin
                stray_idle_req = 0;
                rd_bus.rd_done = 1'b1;
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    int cyc = 0;
    int obs_rs = 0, obs_fv = 0, obs_to = 0;
    int last_rs = 0, last_fv = 0, last_to = 0, last_start = 0;
    bit m_idle, m_busy, m_err, m_in_wait;
    int m_icnt, m_k, exp_rs, exp_fv, exp_to;
    logic [15:0] m_head, m_roll, m_pitch;
    logic [7:0] m_b [6];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_idle = 1; m_icnt = 0; m_busy = 0; m_err = 0; m_in_wait = 0;
                m_k = 0; exp_rs = -1; exp_fv = -1; exp_to = -1;
                m_head = 0; m_roll = 0; m_pitch = 0;
            end else begin
                if (cyc == exp_fv) begin
                    m_head  = {m_b[1], m_b[0]};
                    m_roll  = {m_b[3], m_b[2]};
                    m_pitch = {m_b[5], m_b[4]};
                    m_err = 0; m_busy = 0; m_idle = 1; m_icnt = 0;
                end
                if (cyc == exp_to) begin
                    m_err = 1; m_busy = 0; m_idle = 1; m_icnt = 0;
                end
            end
            chk("rd_start", 32'(rd_bus.rd_start), 32'(cyc == exp_rs));
            chk("frame_valid", 32'(fv), 32'(cyc == exp_fv));
            chk("timeout", 32'(tmo), 32'(cyc == exp_to));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("err_flag", 32'(err), 32'(m_err));
            chk("heading", 32'(heading), 32'(m_head));
            chk("roll", 32'(roll), 32'(m_roll));
            chk("pitch", 32'(pitch), 32'(m_pitch));
            if (!rst_n)
                chk("rd_addr_rst", 32'(rd_bus.rd_addr), 32'h0);
            else if (cyc == exp_rs || m_in_wait)
                chk("rd_addr", 32'(rd_bus.rd_addr), 32'(8'(BASE + 8'(m_k))));
            if (rd_bus.rd_start) begin obs_rs++; last_rs = cyc; end
            if (fv) begin obs_fv++; last_fv = cyc; end
            if (tmo) begin obs_to++; last_to = cyc; end
            if (rst_n) begin
                if (start) last_start = cyc;
                if (m_idle && (start || m_icnt == POLL - 1)) begin
                    m_idle = 0; m_busy = 1; m_k = 0; exp_rs = cyc + 1;
                end else if (m_idle) begin
                    m_icnt++;
                end
                if (cyc == exp_rs) begin
                    m_in_wait = 1;
                    m_icnt = cyc + TMO;
                end else if (m_in_wait) begin
                    if (rd_bus.rd_done) begin
                        m_b[m_k] = rd_bus.rd_data;
                        m_in_wait = 0;
                        if (m_k == 5) exp_fv = cyc + 3;
                        else begin m_k++; exp_rs = cyc + 2; end
                    end else if (cyc == m_icnt) begin
                        m_in_wait = 0;
                        exp_to = cyc + 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int maxc);
        int n0 = obs_fv + obs_to;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (obs_fv + obs_to != n0) return;
        end
        n_chk++;
        $display("FAIL %s: no frame end within %0d cycles", nm, maxc);
    endtask

    task automatic wait_rs(input string nm, input int n, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (obs_rs >= n) return;
            step();
        end
        n_chk++;
        $display("FAIL %s: read %0d not issued within %0d cycles", nm, n, maxc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rs0, fv0, to0;
        logic [15:0] keep_h;
        step(3);
        chk("reset_heading", 32'(heading), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step(3);

        // known frame, fixed latency 5
        table_mode = 1; resp_lat = 5;
        rs0 = obs_rs; fv0 = obs_fv;
        pulse_start();
        wait_end("t1", 400);
        chk("t1_reads", 32'(obs_rs - rs0), 32'd6);
        chk("t1_frames", 32'(obs_fv - fv0), 32'd1);
        chk("t1_latency", 32'(last_fv - last_start), 32'd44);
        chk("t1_heading", 32'(heading), 32'h0010);
        chk("t1_roll", 32'(roll), 32'hFFF0);
        chk("t1_pitch", 32'(pitch), 32'h0020);

        // restarts while busy are dropped
        table_mode = 0;
        rs0 = obs_rs; fv0 = obs_fv;
        pulse_start();
        step(2); pulse_start();
        step(16); pulse_start();
        wait_end("t2", 400);
        chk("t2_reads", 32'(obs_rs - rs0), 32'd6);
        chk("t2_frames", 32'(obs_fv - fv0), 32'd1);
        keep_h = m_head;

        // third byte never completes
        withhold_k = 2; resp_lat = 4;
        rs0 = obs_rs; to0 = obs_to; fv0 = obs_fv;
        pulse_start();
        wait_end("t3", 600);
        chk("t3_timeouts", 32'(obs_to - to0), 32'd1);
        chk("t3_reads", 32'(obs_rs - rs0), 32'd3);
        chk("t3_frames", 32'(obs_fv - fv0), 32'd0);
        chk("t3_to_latency", 32'(last_to - last_rs), 32'(TMO + 1));
        step();
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_hold", 32'(heading), 32'(keep_h));
        withhold_k = -1;
        pulse_start();
        wait_end("t3b", 400);
        chk("t3b_err_clr", 32'(err), 32'd0);

        // auto-poll 50 cycles after frame end
        lat_rand = 1;
        wait_rs("t4_poll", obs_rs + 1, 100);
        chk("t4_poll_gap", 32'(last_rs - last_fv), 32'(POLL));
        wait_end("t4a", 400);
        step(48);
        rs0 = obs_rs; fv0 = obs_fv;
        pulse_start();
        wait_end("t4b", 400);
        step(10);
        chk("t4_coincide_reads", 32'(obs_rs - rs0), 32'd6);
        chk("t4_coincide_frames", 32'(obs_fv - fv0), 32'd1);

        // reset in the middle of the fourth read
        lat_rand = 0; resp_lat = 6;
        rs0 = obs_rs; fv0 = obs_fv;
        pulse_start();
        wait_rs("t5", rs0 + 4, 200);
        step(2);
        rst_n = 1'b0;
        step();
        chk("t5_rst_heading", 32'(heading), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("t5_no_frame", 32'(obs_fv - fv0), 32'd0);
        rs0 = obs_rs; resp_lat = 5;
        pulse_start();
        wait_end("t5b", 400);
        chk("t5b_reads", 32'(obs_rs - rs0), 32'd6);
        chk("t5b_frames", 32'(obs_fv - fv0), 32'd1);

        // completions outside WAIT are ignored
        stray_store = 1;
        pulse_start();
        wait_end("t6", 400);
        stray_store = 0;
        stray_idle_req = 1;
        step(4);
        chk("t6_idle_busy", 32'(busy), 32'd0);

        // randomized traffic
        lat_rand = 1;
        for (int i = 0; i < 10; i++) begin
            withhold_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            stray_store = 1'($urandom);
            step($urandom_range(0, 60));
            pulse_start();
            step($urandom_range(0, 30));
            if ($urandom_range(0, 1) == 1) pulse_start();
            wait_end("rand", 800);
        end
        withhold_k = -1;
        step(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bno055_euler_sequencer.md
Name: bno055_euler_sequencer

Overview:
- Upstream/downstream companion of the single-byte BNO055 read core (bno055_read): issues six single-byte reads of the Euler registers 0x1A..0x1F and assembles them into signed 16-bit heading, roll and pitch words.
- Sits between the I2C read core and the attitude-indicator display/render logic.
- Triggered by a start pulse or by an internal poll timer; per-read timeout guards against a hung bus.

Parameters:
- BASE_ADDR, 8'h1A, first Euler register (EUL_Heading_LSB); six consecutive addresses read.
- POLL_CYCLES, 0, auto-trigger interval in i_clk cycles after each frame end; 0 disables auto-polling.
- TIMEOUT_CYCLES, 1_000_000, maximum cycles waiting for i_rd_done per byte before abort.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request to read one frame
- o_rd_addr  out  8  register address to read core; stable from issue until done/abort
- o_rd_start  out  1  one-cycle read request to read core
- i_rd_data  in  8  byte from read core; valid when i_rd_done=1
- i_rd_done  in  1  one-cycle completion from read core
- o_heading  out  16  signed, 16 LSB/deg
- o_roll  out  16  signed, 16 LSB/deg
- o_pitch  out  16  signed, 16 LSB/deg
- o_frame_valid  out  1  one-cycle pulse when a new frame is published
- o_busy  out  1  high from trigger accept until frame end or abort
- o_timeout  out  1  one-cycle pulse on abort
- o_err_flag  out  1  sticky; set on abort, cleared on next published frame

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; state IDLE; byte index 0; poll counter 0; byte buffer 0.
- States: IDLE, ISSUE, WAIT, STORE, PUBLISH.
- IDLE: trigger = i_start OR (POLL_CYCLES!=0 AND poll counter == POLL_CYCLES-1). On trigger: index=0, o_busy=1, go ISSUE next cycle.
- ISSUE (one cycle): o_rd_addr = BASE_ADDR+index; o_rd_start=1; timeout counter cleared; go WAIT.
- WAIT:
  - On i_rd_done: capture i_rd_data into byte[index]; go STORE.
  - When timeout counter reaches TIMEOUT_CYCLES-1 with no done: o_timeout pulse, o_err_flag=1, o_busy=0, output words unchanged, go IDLE.
- STORE: if index==5 go PUBLISH; else index+1, go ISSUE. The next o_rd_start is therefore exactly 2 cycles after the previous i_rd_done.
- PUBLISH (one cycle), little-endian assembly:
  - o_heading={byte1,byte0}; o_roll={byte3,byte2}; o_pitch={byte5,byte4}.
  - All three update in the same cycle.
  - o_frame_valid=1, o_err_flag=0, o_busy=0 registered so they appear with the new words; go IDLE.
- Output words hold their last published value between frames and after an abort; a partial frame is never visible.
- i_start while o_busy=1: ignored, not queued.
- i_rd_done outside WAIT: ignored.
- i_rd_done in the same cycle the timeout fires: done wins, no abort.
- Poll counter:
  - Counts only in IDLE; cleared on leaving IDLE.
  - i_start and poll expiry in the same cycle give a single frame.
- Latency: i_start at cycle N gives o_rd_start at N+1. With read-core latency L per byte, o_frame_valid occurs at N+1+6*(L+2)+1.
- Reset mid-frame: immediate return to IDLE, outputs zeroed. The read core is reset by the same net.
- Address arithmetic is 8-bit with wrap. BASE_ADDR=8'hFF wraps to 8'h00..8'h04; documented, not an error.

Decomposition:
- bno055_pkg holds:
  - BNO055 register address constants (EUL_BASE=8'h1A, CHIP_ID=8'h00)
  - EUL_FRAME_BYTES=6
  - EUL_LSB_PER_DEG=16
  - the state encoding localparams
- One natural sub-module: bno055_poll_timer, a counter with enable/clear and a terminal-count pulse; instantiated for both the poll interval and the timeout.

Test Plan:
- Reset then i_start; model replies 10,00,F0,FF,20,00 with L=5 -> addresses 1A..1F in order; one o_frame_valid; heading=0x0010, roll=0xFFF0 (-1 deg), pitch=0x0020.
- i_start pulsed again in cycles 3 and 20 of a frame -> ignored; exactly six o_rd_start pulses; one o_frame_valid.
- Model withholds i_rd_done on 3rd byte, TIMEOUT_CYCLES=100 -> o_timeout pulse at cycle 100 of WAIT; o_err_flag=1; o_busy=0; words retain the previous frame. A following good frame clears o_err_flag.
- POLL_CYCLES=50 with no i_start -> frames start 50 cycles after each frame end; i_start coinciding with expiry gives one frame.
- i_rst_n asserted asynchronously mid-WAIT of byte 4 -> all outputs 0 immediately; no o_frame_valid; after release, i_start yields a clean full frame.
- Stray i_rd_done in IDLE and in STORE -> no state change, no data capture.
